// File: rtl/mbimager_pkg.sv
// Shared definitions for the mbimager frame scheduler.
// State codes double as the sched_stat encoding.
package mbimager_pkg;

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_FLUSH       = 4'd1,
    S_LOAD        = 4'd2,
    S_REL         = 4'd3,
    S_WAIT_RDREQ  = 4'd4,
    S_ACK_RD      = 4'd5,
    S_WAIT_RDDONE = 4'd6
  } sched_state_t;

  typedef enum logic [1:0] {
    FL_REQ  = 2'd0,
    FL_ACK  = 2'd1,
    FL_DONE = 2'd2
  } flush_ph_t;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_BURST  = 2'd1;
  localparam logic [1:0] MODE_CONT   = 2'd2;

  localparam logic [31:0] DEF_EXP  = 32'd10;
  localparam logic [31:0] DEF_NPAT = 32'd100;

endpackage

// File: rtl/exposure_scheduler_sync_bit.sv
// Flop-chain synchronizer for single-bit CLKMPRE-domain signals.
// Synchronous active-high reset clears the chain.
module sync_bit #(
  parameter int C_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [C_STAGES-1:0] chain_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain_q <= '0;
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < C_STAGES; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  assign q_o = chain_q[C_STAGES-1];

endmodule

// File: rtl/exposure_scheduler.sv
// Frame scheduler driving the exposure FSM start/readout handshakes
// and presenting per-frame Exp_subc/Num_Pat from a host table.
module exposure_scheduler
  import mbimager_pkg::*;
#(
  parameter int          C_NUM_CFG     = 4,
  parameter int          C_SYNC_STAGES = 2,
  parameter logic [31:0] C_TIMEOUT     = 32'd100_000_000
) (
  input  logic                         CLK_HS,
  input  logic                         RESET,
  input  logic                         CFG_WE,
  input  logic [$clog2(C_NUM_CFG)-1:0] CFG_ADDR,
  input  logic [31:0]                  CFG_EXP,
  input  logic [31:0]                  CFG_NPAT,
  input  logic [$clog2(C_NUM_CFG):0]   NUM_CFG_USED,
  input  logic [1:0]                   MODE,
  input  logic [15:0]                  BURST_LEN,
  input  logic                         START,
  input  logic                         STOP,
  input  logic                         RDOUT_DONE,
  input  logic                         FSMIND0ACK,
  input  logic                         FSMIND1,
  output logic                         FSMIND0,
  output logic                         FSMIND1ACK,
  output logic [31:0]                  Exp_subc,
  output logic [31:0]                  Num_Pat,
  output logic                         BUSY,
  output logic [31:0]                  FRAME_CNT,
  output logic [$clog2(C_NUM_CFG)-1:0] CFG_IDX,
  output logic                         ERR_TIMEOUT,
  output logic [3:0]                   sched_stat
);

  localparam int         IW     = $clog2(C_NUM_CFG);
  localparam logic [IW:0] ONE_W = 1;
  localparam logic [IW:0] NCFG_W = C_NUM_CFG[IW:0];

  sched_state_t state_q, state_d;
  flush_ph_t    fph_q, fph_d;
  logic [31:0]  tmo_q, tmo_d;
  logic [15:0]  rem_q, rem_d;
  logic         cont_q, cont_d;
  logic         stop_q, stop_d;
  logic         err_q, err_d;
  logic [31:0]  fcnt_q, fcnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]  exp_q, npat_q;
  logic         ind0_q, ind1ack_q, busy_q;

  logic [31:0]  tab_exp_q  [C_NUM_CFG];
  logic [31:0]  tab_npat_q [C_NUM_CFG];

  logic         ack_s, ind1_s, waiting;
  logic [IW:0]  n_used, idx_inc, idx_mod;

  sync_bit #(.C_STAGES(C_SYNC_STAGES)) u_sync_ack (
    .clk_i (CLK_HS),
    .rst_i (RESET),
    .d_i   (FSMIND0ACK),
    .q_o   (ack_s)
  );

  sync_bit #(.C_STAGES(C_SYNC_STAGES)) u_sync_rdreq (
    .clk_i (CLK_HS),
    .rst_i (RESET),
    .d_i   (FSMIND1),
    .q_o   (ind1_s)
  );

  always_comb begin
    n_used = NUM_CFG_USED;
    if (NUM_CFG_USED == '0) begin
      n_used = ONE_W;
    end else if (NUM_CFG_USED > NCFG_W) begin
      n_used = NCFG_W;
    end
  end

  assign idx_inc = {1'b0, idx_q} + ONE_W;
  assign idx_mod = idx_inc % n_used;
  assign waiting = (state_q == S_REL) || (state_q == S_WAIT_RDREQ) ||
                   (state_q == S_ACK_RD) || (state_q == S_WAIT_RDDONE);

  always_comb begin
    state_d = state_q;
    fph_d   = fph_q;
    rem_d   = rem_q;
    cont_d  = cont_q;
    stop_d  = stop_q;
    err_d   = err_q;
    fcnt_d  = fcnt_q;
    idx_d   = idx_q;
    if (STOP && state_q != S_IDLE) stop_d = 1'b1;
    unique case (state_q)
      S_FLUSH: begin
        unique case (fph_q)
          FL_REQ: if (ind1_s) fph_d = FL_ACK;
          FL_ACK: if (!ind1_s) fph_d = FL_DONE;
          default: begin
            if (RDOUT_DONE) begin
              fph_d   = FL_REQ;
              state_d = S_IDLE;
            end
          end
        endcase
      end
      S_IDLE: begin
        stop_d = 1'b0;
        if (START && !STOP) begin
          err_d   = 1'b0;
          cont_d  = (MODE == MODE_CONT);
          rem_d   = 16'd1;
          if (MODE == MODE_BURST && BURST_LEN != 16'd0) rem_d = BURST_LEN;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_REL;
      S_REL: begin
        if (ack_s) begin
          fcnt_d  = fcnt_q + 32'd1;
          if (!cont_q) rem_d = rem_q - 16'd1;
          state_d = S_WAIT_RDREQ;
        end
      end
      S_WAIT_RDREQ: if (ind1_s) state_d = S_ACK_RD;
      S_ACK_RD: if (!ind1_s) state_d = S_WAIT_RDDONE;
      S_WAIT_RDDONE: begin
        if (RDOUT_DONE) begin
          idx_d = idx_mod[IW-1:0];
          if (stop_d || (!cont_q && rem_q == 16'd0)) state_d = S_IDLE;
          else state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Watchdog overrides any handshake progress in the same cycle
    if (waiting && tmo_q == C_TIMEOUT - 32'd1) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end
    tmo_d = (state_d != state_q) ? 32'd0 : tmo_q + 32'd1;
  end

  always_ff @(posedge CLK_HS) begin
    if (RESET) begin
      state_q   <= S_FLUSH;
      fph_q     <= FL_REQ;
      tmo_q     <= '0;
      rem_q     <= '0;
      cont_q    <= 1'b0;
      stop_q    <= 1'b0;
      err_q     <= 1'b0;
      fcnt_q    <= '0;
      idx_q     <= '0;
      exp_q     <= DEF_EXP;
      npat_q    <= DEF_NPAT;
      ind0_q    <= 1'b0;
      ind1ack_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fph_q     <= fph_d;
      tmo_q     <= tmo_d;
      rem_q     <= rem_d;
      cont_q    <= cont_d;
      stop_q    <= stop_d;
      err_q     <= err_d;
      fcnt_q    <= fcnt_d;
      idx_q     <= idx_d;
      ind0_q    <= (state_d == S_REL);
      ind1ack_q <= (state_d == S_ACK_RD) ||
                   (state_d == S_FLUSH && fph_d == FL_ACK);
      busy_q    <= (state_d != S_IDLE);
      if (state_d == S_LOAD && state_q != S_LOAD) begin
        exp_q  <= tab_exp_q[idx_d];
        npat_q <= tab_npat_q[idx_d];
      end
    end
  end

  always_ff @(posedge CLK_HS) begin
    if (RESET) begin
      for (int i = 0; i < C_NUM_CFG; i++) begin
        tab_exp_q[i]  <= DEF_EXP;
        tab_npat_q[i] <= DEF_NPAT;
      end
    end else if (CFG_WE) begin
      tab_exp_q[CFG_ADDR]  <= CFG_EXP;
      tab_npat_q[CFG_ADDR] <= CFG_NPAT;
    end
  end

  assign FSMIND0     = ind0_q;
  assign FSMIND1ACK  = ind1ack_q;
  assign Exp_subc    = exp_q;
  assign Num_Pat     = npat_q;
  assign BUSY        = busy_q;
  assign FRAME_CNT   = fcnt_q;
  assign CFG_IDX     = idx_q;
  assign ERR_TIMEOUT = err_q;
  assign sched_stat  = state_q;

endmodule

// File: tb/tb_exposure_scheduler.sv
// Bench for exposure_scheduler: responder models the exposure FSM and
// ADC side; expected frames come from a table/modulo reference model.
module tb_exposure_scheduler;

  logic        CLK_HS = 1'b0;
  logic        RESET = 1'b1;
  logic        CFG_WE = 1'b0;
  logic [1:0]  CFG_ADDR = '0;
  logic [31:0] CFG_EXP = '0;
  logic [31:0] CFG_NPAT = '0;
  logic [2:0]  NUM_CFG_USED = 3'd1;
  logic [1:0]  MODE = 2'd0;
  logic [15:0] BURST_LEN = 16'd1;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic        RDOUT_DONE;
  logic        FSMIND0ACK;
  logic        FSMIND1;
  logic        FSMIND0, FSMIND1ACK, BUSY, ERR_TIMEOUT;
  logic [31:0] Exp_subc, Num_Pat, FRAME_CNT;
  logic [1:0]  CFG_IDX;
  logic [3:0]  sched_stat;

  exposure_scheduler #(
    .C_NUM_CFG(4), .C_SYNC_STAGES(2), .C_TIMEOUT(32'd50)
  ) dut (
    .CLK_HS(CLK_HS), .RESET(RESET), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR),
    .CFG_EXP(CFG_EXP), .CFG_NPAT(CFG_NPAT), .NUM_CFG_USED(NUM_CFG_USED),
    .MODE(MODE), .BURST_LEN(BURST_LEN), .START(START), .STOP(STOP),
    .RDOUT_DONE(RDOUT_DONE), .FSMIND0ACK(FSMIND0ACK), .FSMIND1(FSMIND1),
    .FSMIND0(FSMIND0), .FSMIND1ACK(FSMIND1ACK), .Exp_subc(Exp_subc),
    .Num_Pat(Num_Pat), .BUSY(BUSY), .FRAME_CNT(FRAME_CNT),
    .CFG_IDX(CFG_IDX), .ERR_TIMEOUT(ERR_TIMEOUT), .sched_stat(sched_stat)
  );

  always #5 CLK_HS = ~CLK_HS;

  int checks = 0;
  int errors = 0;
  bit auto_ack = 1'b1;
  int ph;
  int dly;

  // Exposure FSM / ADC responder; self-starts a readout after reset
  always @(negedge CLK_HS) begin
    RDOUT_DONE = 1'b0;
    if (RESET) begin
      ph = 2; dly = 2; FSMIND0ACK = 1'b0; FSMIND1 = 1'b0;
    end else begin
      case (ph)
        0: if (FSMIND0 && auto_ack) begin FSMIND0ACK = 1'b1; ph = 1; end
        1: if (!FSMIND0) begin
             FSMIND0ACK = 1'b0; dly = int'($urandom_range(1, 5)); ph = 2;
           end
        2: if (dly > 0) dly--; else begin FSMIND1 = 1'b1; ph = 3; end
        3: if (FSMIND1ACK) begin FSMIND1 = 1'b0; ph = 4; end
        4: if (!FSMIND1ACK) begin dly = int'($urandom_range(0, 4)); ph = 5; end
        default: if (dly > 0) dly--; else begin RDOUT_DONE = 1'b1; ph = 0; end
      endcase
    end
  end

  logic [63:0] fq[$];
  always @(posedge FSMIND0) fq.push_back({Exp_subc, Num_Pat});

  logic [31:0] m_exp [4];
  logic [31:0] m_npat[4];
  int          midx;
  logic [31:0] mframes;
  logic [63:0] eq[$];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge CLK_HS);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_exp[i] = 32'd10; m_npat[i] = 32'd100; end
    midx = 0; mframes = 0;
  endtask

  function automatic int used_eff();
    int u;
    u = int'(NUM_CFG_USED);
    if (u == 0) u = 1;
    if (u > 4) u = 4;
    return u;
  endfunction

  task automatic model_run(input int n);
    eq.delete();
    for (int k = 0; k < n; k++) begin
      eq.push_back({m_exp[midx], m_npat[midx]});
      midx = (midx + 1) % used_eff();
      mframes++;
    end
  endtask

  task automatic cfg_write(input int a, input logic [31:0] e, input logic [31:0] n);
    CFG_WE = 1'b1; CFG_ADDR = 2'(a); CFG_EXP = e; CFG_NPAT = n;
    tick();
    CFG_WE = 1'b0;
    m_exp[a] = e; m_npat[a] = n;
  endtask

  task automatic pulse_start();
    START = 1'b1; tick(); START = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (BUSY && n < 3000) begin tick(); n++; end
    check({tag, "_idle_to"}, BUSY, 0);
  endtask

  task automatic wait_state(input logic [3:0] s, input string tag);
    int n = 0;
    while (sched_stat !== s && n < 3000) begin tick(); n++; end
    check({tag, "_state_to"}, sched_stat, s);
  endtask

  task automatic cmp_frames(input string tag);
    check({tag, "_nframes"}, fq.size(), eq.size());
    for (int k = 0; k < eq.size() && k < fq.size(); k++)
      check($sformatf("%s_frame%0d", tag, k), fq[k], eq[k]);
    check({tag, "_fcnt"}, FRAME_CNT, mframes);
    check({tag, "_idx"}, CFG_IDX, midx);
  endtask

  initial begin
    logic [63:0] pres;
    int n;
    model_reset();
    repeat (3) tick();
    check("rst_stat", sched_stat, 1);
    check("rst_ind0", FSMIND0, 0);
    check("rst_ind1ack", FSMIND1ACK, 0);
    check("rst_busy", BUSY, 0);
    check("rst_err", ERR_TIMEOUT, 0);
    check("rst_fcnt", FRAME_CNT, 0);
    check("rst_idx", CFG_IDX, 0);
    check("rst_exp", Exp_subc, 10);
    check("rst_npat", Num_Pat, 100);
    RESET = 1'b0;

    // Flush: FSMIND1ACK rises three cycles after FSMIND1
    n = 0;
    while (!FSMIND1 && n < 50) begin tick(); n++; end
    check("flush_req_to", FSMIND1, 1);
    tick(); tick();
    check("flush_ack_early", FSMIND1ACK, 0);
    tick();
    check("flush_ack3", FSMIND1ACK, 1);
    check("flush_stat", sched_stat, 1);
    wait_state(4'd0, "flush");
    check("flush_fcnt", FRAME_CNT, 0);
    check("flush_busy", BUSY, 0);

    // Burst of 3 over two entries
    for (int i = 0; i < 4; i++) cfg_write(i, $urandom_range(1, 999), $urandom_range(1, 999));
    NUM_CFG_USED = 3'd2; MODE = 2'd1; BURST_LEN = 16'd3;
    fq.delete();
    START = 1'b1; tick(); START = 1'b0;
    check("lat_ind0_lo", FSMIND0, 0);
    check("lat_load", sched_stat, 2);
    check("lat_exp", Exp_subc, m_exp[midx]);
    tick();
    check("lat_ind0_hi", FSMIND0, 1);
    wait_idle("burst");
    model_run(3);
    cmp_frames("burst");

    // Randomized single/burst runs with odd NUM_CFG_USED and BURST_LEN
    for (int it = 0; it < 5; it++) begin
      int m;
      m = int'($urandom_range(0, 2));
      if (m == 2) m = 3;
      MODE = 2'(m);
      NUM_CFG_USED = 3'($urandom_range(0, 7));
      BURST_LEN = 16'($urandom_range(0, 4));
      cfg_write(int'($urandom_range(0, 3)), $urandom, $urandom);
      fq.delete();
      pulse_start();
      wait_idle($sformatf("rnd%0d", it));
      model_run((m == 1) ? ((BURST_LEN == 0) ? 1 : int'(BURST_LEN)) : 1);
      cmp_frames($sformatf("rnd%0d", it));
    end

    // Continuous mode stopped during frame 4 read request wait
    MODE = 2'd2; NUM_CFG_USED = 3'd3;
    fq.delete();
    pulse_start();
    n = 0;
    while (!(sched_stat == 4 && FRAME_CNT == mframes + 4) && n < 3000) begin tick(); n++; end
    check("cont_reach_f4", FRAME_CNT, mframes + 4);
    STOP = 1'b1; tick(); STOP = 1'b0;
    wait_idle("cont");
    model_run(4);
    cmp_frames("cont");
    repeat (20) tick();
    check("cont_no_f5", fq.size(), 4);

    // Timeout with no FSMIND0ACK
    auto_ack = 1'b0; MODE = 2'd0;
    START = 1'b1; tick(); START = 1'b0; tick();
    check("tmo_rel", FSMIND0, 1);
    repeat (49) tick();
    check("tmo_before", ERR_TIMEOUT, 0);
    tick();
    check("tmo_err", ERR_TIMEOUT, 1);
    check("tmo_ind0", FSMIND0, 0);
    check("tmo_stat", sched_stat, 0);
    auto_ack = 1'b1;
    fq.delete();
    START = 1'b1; tick(); START = 1'b0;
    check("tmo_clear", ERR_TIMEOUT, 0);
    wait_idle("tmo_rerun");
    model_run(1);
    cmp_frames("tmo_rerun");

    // START with STOP in the same cycle
    START = 1'b1; STOP = 1'b1; tick(); START = 1'b0; STOP = 1'b0;
    check("ss_stat", sched_stat, 0);
    tick();
    check("ss_busy", BUSY, 0);

    // Table write to entry 0 while presenting it
    NUM_CFG_USED = 3'd1; MODE = 2'd0;
    fq.delete();
    pulse_start();
    wait_state(4'd6, "wr");
    model_run(1);
    pres = eq[0];
    cfg_write(0, $urandom, $urandom);
    check("wr_exp_hold", Exp_subc, pres[63:32]);
    wait_idle("wr");
    check("wr_exp_idle", Exp_subc, pres[63:32]);
    cmp_frames("wr");
    fq.delete();
    pulse_start();
    wait_idle("wr2");
    model_run(1);
    cmp_frames("wr2");
    check("wr2_exp", Exp_subc, m_exp[0]);

    // Reset in S_ACK_RD
    MODE = 2'd1; BURST_LEN = 16'd2;
    pulse_start();
    wait_state(4'd5, "rr");
    RESET = 1'b1; tick();
    check("rr_ind1ack", FSMIND1ACK, 0);
    check("rr_stat", sched_stat, 1);
    check("rr_idx", CFG_IDX, 0);
    check("rr_fcnt", FRAME_CNT, 0);
    check("rr_exp", Exp_subc, 10);
    RESET = 1'b0;
    model_reset();
    wait_state(4'd0, "rr_flush");
    MODE = 2'd0;
    fq.delete();
    pulse_start();
    wait_idle("rr_after");
    model_run(1);
    cmp_frames("rr_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exposure_scheduler.md
# exposure_scheduler

Frame-level scheduler for `exposure_fsm`, clocked on CLK_HS. It owns the exposure FSM's start/readout handshakes (FSMIND0/FSMIND0ACK, FSMIND1/FSMIND1ACK) and presents per-frame Exp_subc/Num_Pat values from a small host-written configuration table. Frames run in single, burst or continuous mode, with readout gated by the ADC side's done pulse and a timeout watchdog.

## Interface
- C_NUM_CFG, 4: configuration table depth (power of 2).
- C_SYNC_STAGES, 2: synchronizer depth for CLKMPRE-domain inputs.
- C_TIMEOUT, 32'd100_000_000: maximum CLK_HS cycles spent in any wait state.
- CLK_HS  in  1  scheduler clock.
- RESET  in  1  synchronous, active-high.
- CFG_WE  in  1  table write strobe.
- CFG_ADDR  in  $clog2(C_NUM_CFG)  table entry.
- CFG_EXP  in  32  Exp_subc value written.
- CFG_NPAT  in  32  Num_Pat value written.
- NUM_CFG_USED  in  $clog2(C_NUM_CFG)+1  entries cycled through; 0 is treated as 1; values above C_NUM_CFG are clamped to C_NUM_CFG.
- MODE  in  2  0 single, 1 burst, 2 continuous, 3 is treated as single.
- BURST_LEN  in  16  frames per burst; 0 is treated as 1.
- START  in  1  one-cycle start pulse.
- STOP  in  1  one-cycle stop pulse.
- RDOUT_DONE  in  1  one-cycle pulse, synchronous to CLK_HS, issued when ADC readout finishes.
- FSMIND0ACK  in  1  from exposure FSM, CLKMPRE domain.
- FSMIND1  in  1  from exposure FSM, CLKMPRE domain.
- FSMIND0  out  1  frame release to exposure FSM.
- FSMIND1ACK  out  1  readout-request acknowledge.
- Exp_subc  out  32  current frame exposure.
- Num_Pat  out  32  current frame pattern count.
- BUSY  out  1  high outside S_IDLE.
- FRAME_CNT  out  32  frames released since reset.
- CFG_IDX  out  $clog2(C_NUM_CFG)  table entry currently presented.
- ERR_TIMEOUT  out  1  sticky; cleared by RESET or START.
- sched_stat  out  4  state encoding.

## Operation
- Reset values:
  - FSMIND0, FSMIND1ACK, BUSY, ERR_TIMEOUT = 0.
  - FRAME_CNT = 0, CFG_IDX = 0.
  - Exp_subc = 10, Num_Pat = 100.
  - Table entries = {10, 100}.
  - State = S_FLUSH.
- Table writes are accepted in every state. A write to the presented entry takes effect only at the next S_LOAD.
- FSMIND0ACK and FSMIND1 each pass through a C_SYNC_STAGES flop chain. Every decision below uses the synchronized copies.
- States (sched_stat value in parentheses):
  - S_FLUSH (1): the exposure FSM self-starts a frame after reset. Same handshake as S_WAIT_RDREQ/S_ACK_RD/S_WAIT_RDDONE; then go to S_IDLE without counting a frame.
  - S_IDLE (0): on START (and no STOP in the same cycle), load the remaining frame count (1, BURST_LEN, or unlimited), clear ERR_TIMEOUT, go to S_LOAD.
  - S_LOAD (2): latch table[CFG_IDX] into Exp_subc/Num_Pat, go to S_REL.
  - S_REL (3): FSMIND0 = 1 until FSMIND0ACK is seen high. Then FSMIND0 = 0, FRAME_CNT += 1, decrement remaining, go to S_WAIT_RDREQ.
  - S_WAIT_RDREQ (4): wait for FSMIND1 high, then go to S_ACK_RD.
  - S_ACK_RD (5): FSMIND1ACK = 1 until FSMIND1 is seen low. Then FSMIND1ACK = 0, go to S_WAIT_RDDONE.
  - S_WAIT_RDDONE (6): on RDOUT_DONE, advance CFG_IDX modulo NUM_CFG_USED. Go to S_IDLE if remaining = 0 or a stop is pending; otherwise go to S_LOAD.
- STOP in any non-idle state sets stop_pending. The current frame's handshakes complete, then the block returns to S_IDLE. stop_pending clears in S_IDLE.
- START while BUSY is ignored.
- If START and STOP arrive in the same cycle, STOP wins.
- In continuous mode the remaining count does not decrement.
- Timeout: a 32-bit counter clears on every state change. In S_REL, S_WAIT_RDREQ, S_ACK_RD or S_WAIT_RDDONE, reaching C_TIMEOUT sets ERR_TIMEOUT, drops FSMIND0/FSMIND1ACK and goes to S_IDLE.
- FRAME_CNT wraps from 2^32-1 to 0.
- RESET mid-frame returns every output to its reset value and the state to S_FLUSH in the following cycle.

## Timing
- From START to FSMIND0 high: 2 cycles (S_IDLE→S_LOAD→S_REL).
- Exp_subc/Num_Pat change only on the S_LOAD edge. They are stable for at least 1 cycle before FSMIND0 rises and until the next S_LOAD.
- Handshake input latency: C_SYNC_STAGES cycles plus 1.
- All outputs are registered.

## Structure
- Shared package `mbimager_pkg`:
  - state localparams;
  - MODE encodings (MODE_SINGLE, MODE_BURST, MODE_CONT);
  - default exposure/pattern constants (10, 100).
- One sub-module, `sync_bit`: a parameterized flop-chain synchronizer, instantiated twice.
- The configuration table is an inline register array.

## Test plan
- Reset, model exposure FSM raises FSMIND1 -> FSMIND1ACK after 3 cycles; RDOUT_DONE -> S_IDLE, FRAME_CNT = 0.
- Table {(5,8),(20,50)}, NUM_CFG_USED = 2, MODE = 1, BURST_LEN = 3, START -> frames use 5/8, 20/50, 5/8; FRAME_CNT = 3; BUSY falls after the third RDOUT_DONE.
- MODE = 2, STOP during S_WAIT_RDREQ of frame 4 -> readout completes, no fifth FSMIND0, FRAME_CNT = 4.
- C_TIMEOUT = 50, FSMIND0ACK never returned -> ERR_TIMEOUT = 1 at cycle 50 of S_REL, FSMIND0 = 0, S_IDLE; a following START clears ERR_TIMEOUT.
- START and STOP in the same cycle -> stays S_IDLE. Write entry 0 during S_WAIT_RDDONE -> new value appears on Exp_subc only at the next S_LOAD.
- RESET asserted in S_ACK_RD -> FSMIND1ACK = 0 the next cycle, state S_FLUSH, CFG_IDX = 0.
